// File: rtl/common_types_pkg.sv
// Shared types for the memory-side blocks: the word type, the arbiter
// state encoding, the grant encoding and the grant-selection helper.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // Picks the port to serve. A lone requester always wins. When both ports
    // request, round-robin flips away from the previous grant. Fixed priority
    // always favours the data port.
    function automatic grant_t pickGrant(
        input logic   iReq,
        input logic   dReq,
        input grant_t lastGrant,
        input logic   rrEn
    );
        grant_t result;
        result = GRANT_I;
        if (iReq && dReq) begin
            if (!rrEn) begin
                result = GRANT_D;
            end else if (lastGrant == GRANT_I) begin
                result = GRANT_D;
            end else begin
                result = GRANT_I;
            end
        end else if (dReq) begin
            result = GRANT_D;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single RAM port with a
// ready handshake. Each access walks IDLE -> ISSUE -> WAIT -> RESP. A WAIT that
// runs too long is abandoned with a one-cycle abort pulse.
module mem_arbiter
    import common_types_pkg::*;
#(
    parameter bit          RR_EN        = 1'b1,
    parameter int unsigned RAM_WAIT_MAX = 255
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  iren,
    input  word_t iaddr,
    output word_t iload,
    output logic  ihit,
    input  logic  dren,
    input  logic  dwen,
    input  word_t daddr,
    input  word_t dstore,
    output word_t dload,
    output logic  dhit,
    output word_t ram_addr,
    output word_t ram_store,
    output logic  ram_ren,
    output logic  ram_wen,
    input  word_t ram_load,
    input  logic  ram_ready,
    output logic  abort
);

    // The WAIT counter runs 0 .. RAM_WAIT_MAX-1. The abort fires when ready
    // is still low in the cycle where the counter sits on its last value.
    localparam int CNT_W = (RAM_WAIT_MAX < 2) ? 1 : $clog2(RAM_WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RAM_WAIT_MAX - 1);

    arb_state_t       r_state;
    grant_t           r_lastGrant;
    logic [CNT_W-1:0] r_waitCnt;

    logic   w_dReq;
    logic   w_anyReq;
    grant_t w_grantNext;

    // Request decode and grant selection. This is only acted upon in IDLE.
    always_comb begin
        w_dReq      = dren | dwen;
        w_anyReq    = iren | w_dReq;
        w_grantNext = pickGrant(iren, w_dReq, r_lastGrant, RR_EN);
    end

    // Access sequencer. All outputs are registered and change on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_I;
            r_waitCnt   <= '0;
            ram_addr    <= '0;
            ram_store   <= '0;
            ram_ren     <= 1'b0;
            ram_wen     <= 1'b0;
            iload       <= '0;
            dload       <= '0;
            ihit        <= 1'b0;
            dhit        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            ihit  <= 1'b0;
            dhit  <= 1'b0;
            abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_lastGrant <= w_grantNext;
                        if (w_grantNext == GRANT_D) begin
                            ram_addr  <= daddr;
                            ram_store <= dstore;
                            ram_wen   <= dwen;
                            ram_ren   <= ~dwen;
                        end else begin
                            ram_addr  <= iaddr;
                            ram_store <= '0;
                            ram_wen   <= 1'b0;
                            ram_ren   <= 1'b1;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (ram_ready) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        if (r_lastGrant == GRANT_D) begin
                            dhit <= 1'b1;
                            if (!ram_wen) begin
                                dload <= ram_load;
                            end
                        end else begin
                            ihit  <= 1'b1;
                            iload <= ram_load;
                        end
                        r_state <= RESP;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        abort   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share the port inputs: dutRr
// uses round-robin and dutFp uses fixed data priority. Each instance has its own
// RAM model with a programmable ready latency, a stall and an address-derived
// load option.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;

    logic [31:0] iloadA    [2];
    logic [31:0] dloadA    [2];
    logic        ihitA     [2];
    logic        dhitA     [2];
    logic [31:0] ramAddr   [2];
    logic [31:0] ramStore  [2];
    logic        ramRen    [2];
    logic        ramWen    [2];
    logic [31:0] ramLoad   [2];
    logic        ramReady  [2];
    logic        abortA    [2];
    int          ramCnt    [2];

    int          ramWait;
    logic        ramStall;
    logic        useAddrData;
    logic [31:0] ramData;

    int compared;
    int mismatched;
    int violations;

    int resHitCyc;
    int resIHits;
    int resDHits;
    int resAborts;
    int resRen;
    int resWen;
    int resBadHold;

    localparam logic [31:0] ADDR_KEY = 32'hA5A5_0000;

    mem_arbiter #(.RR_EN(1'b1), .RAM_WAIT_MAX(8)) dutRr (
        .clk(clk), .rst(rst),
        .iren(iren), .iaddr(iaddr), .iload(iloadA[0]), .ihit(ihitA[0]),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dload(dloadA[0]), .dhit(dhitA[0]),
        .ram_addr(ramAddr[0]), .ram_store(ramStore[0]),
        .ram_ren(ramRen[0]), .ram_wen(ramWen[0]),
        .ram_load(ramLoad[0]), .ram_ready(ramReady[0]),
        .abort(abortA[0])
    );

    mem_arbiter #(.RR_EN(1'b0), .RAM_WAIT_MAX(8)) dutFp (
        .clk(clk), .rst(rst),
        .iren(iren), .iaddr(iaddr), .iload(iloadA[1]), .ihit(ihitA[1]),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dload(dloadA[1]), .dhit(dhitA[1]),
        .ram_addr(ramAddr[1]), .ram_store(ramStore[1]),
        .ram_ren(ramRen[1]), .ram_wen(ramWen[1]),
        .ram_load(ramLoad[1]), .ram_ready(ramReady[1]),
        .abort(abortA[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: counts enabled cycles, and each access restarts from zero.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ramCnt[k] <= (ramRen[k] || ramWen[k]) ? ramCnt[k] + 1 : 0;
        end
    end

    // Ready rises once the access has been enabled for ramWait cycles.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ramReady[k] = 1'b0;
            ramLoad[k]  = ramData;
            ramReady[k] = (ramRen[k] || ramWen[k]) && !ramStall && (ramCnt[k] >= ramWait);
            ramLoad[k]  = useAddrData ? (ramAddr[k] ^ ADDR_KEY) : ramData;
        end
    end

    // Counts cycles where the completion/abort pulses or the RAM enables overlap.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if ((int'(ihitA[k]) + int'(dhitA[k]) + int'(abortA[k])) > 1 || (ramRen[k] && ramWen[k])) begin
                violations <= violations + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst  = 1'b1;
        iren = 1'b0;
        dren = 1'b0;
        dwen = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drives one request pattern and watches dutRr for 16 cycles. It scrambles
    // the address/data inputs once the RAM enable appears, and it drops the
    // requests when the hit or abort arrives.
    task automatic applyStimulus(
        input logic ir, input logic dr, input logic dw,
        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
        input logic [31:0] expAddr, input logic [31:0] expStore,
        input int waitCyc, input logic stall
    );
        logic scrambled;
        resHitCyc  = 0;
        resIHits   = 0;
        resDHits   = 0;
        resAborts  = 0;
        resRen     = 0;
        resWen     = 0;
        resBadHold = 0;
        scrambled  = 1'b0;
        @(negedge clk);
        ramWait  = waitCyc;
        ramStall = stall;
        iren     = ir;
        dren     = dr;
        dwen     = dw;
        iaddr    = ia;
        daddr    = da;
        dstore   = ds;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ramRen[0] || ramWen[0]) begin
                if (ramRen[0]) resRen++;
                if (ramWen[0]) resWen++;
                if (ramAddr[0] !== expAddr || (ramWen[0] && ramStore[0] !== expStore)) resBadHold++;
                if (!scrambled) begin
                    iaddr     = ~ia;
                    daddr     = ~da;
                    dstore    = ~ds;
                    scrambled = 1'b1;
                end
            end
            if (ihitA[0])  resIHits++;
            if (dhitA[0])  resDHits++;
            if (abortA[0]) resAborts++;
            if ((ihitA[0] || dhitA[0] || abortA[0]) && resHitCyc == 0) begin
                resHitCyc = c;
                iren      = 1'b0;
                dren      = 1'b0;
                dwen      = 1'b0;
                ramStall  = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0]  seq0;
        logic [3:0]  seq1;
        int          n0;
        int          n1;
        int          fpIHits;
        logic [31:0] prevLoad;

        compared    = 0;
        mismatched  = 0;
        violations  = 0;
        rst         = 1'b1;
        iren        = 1'b0;
        dren        = 1'b0;
        dwen        = 1'b0;
        iaddr       = '0;
        daddr       = '0;
        dstore      = '0;
        ramWait     = 0;
        ramStall    = 1'b0;
        useAddrData = 1'b0;
        ramData     = '0;

        // Reset state
        doReset();
        checkOutput("rst_ram_ren",   32'(ramRen[0]),   32'h0);
        checkOutput("rst_ram_wen",   32'(ramWen[0]),   32'h0);
        checkOutput("rst_ram_addr",  ramAddr[0],       32'h0);
        checkOutput("rst_ram_store", ramStore[0],      32'h0);
        checkOutput("rst_hits",      32'({ihitA[0], dhitA[0], abortA[0]}), 32'h0);
        checkOutput("rst_loads",     iloadA[0] | dloadA[0], 32'h0);
        rst = 1'b0;

        // Instruction read, ready after three WAIT cycles
        ramData = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h10, 32'h0, 3, 1'b0);
        checkOutput("iread_ren_cycles", 32'(resRen),     32'd4);
        checkOutput("iread_wen_cycles", 32'(resWen),     32'd0);
        checkOutput("iread_ihits",      32'(resIHits),   32'd1);
        checkOutput("iread_dhits",      32'(resDHits),   32'd0);
        checkOutput("iread_latency",    32'(resHitCyc),  32'd5);
        checkOutput("iread_hold",       32'(resBadHold), 32'd0);
        checkOutput("iread_iload",      iloadA[0],       32'hDEAD_BEEF);
        checkOutput("iread_dload",      dloadA[0],       32'h0);

        // Data write: address/store held, dload untouched
        ramData = 32'h1111_2222;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h20, 32'h1234_5678, 32'h20, 32'h1234_5678, 2, 1'b0);
        checkOutput("dwrite_wen_cycles", 32'(resWen),     32'd3);
        checkOutput("dwrite_ren_cycles", 32'(resRen),     32'd0);
        checkOutput("dwrite_dhits",      32'(resDHits),   32'd1);
        checkOutput("dwrite_latency",    32'(resHitCyc),  32'd4);
        checkOutput("dwrite_hold",       32'(resBadHold), 32'd0);
        checkOutput("dwrite_dload",      dloadA[0],       32'h0);
        checkOutput("dwrite_iload",      iloadA[0],       32'hDEAD_BEEF);

        // Data read at the minimum latency
        ramData = 32'h55AA_33CC;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h28, 32'h0, 32'h28, 32'h0, 0, 1'b0);
        checkOutput("dread_ren_cycles", 32'(resRen),    32'd2);
        checkOutput("dread_latency",    32'(resHitCyc), 32'd3);
        checkOutput("dread_dhits",      32'(resDHits),  32'd1);
        checkOutput("dread_dload",      dloadA[0],      32'h55AA_33CC);

        // dren and dwen together resolve to a write
        prevLoad = dloadA[0];
        ramData  = 32'h7777_7777;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h24, 32'h0BAD_F00D, 32'h24, 32'h0BAD_F00D, 0, 1'b0);
        checkOutput("rw_ren_cycles", 32'(resRen),     32'd0);
        checkOutput("rw_wen_cycles", 32'(resWen),     32'd2);
        checkOutput("rw_dhits",      32'(resDHits),   32'd1);
        checkOutput("rw_hold",       32'(resBadHold), 32'd0);
        checkOutput("rw_dload",      dloadA[0],       prevLoad);

        // Ready stuck low: abort after eight WAIT cycles, no hit
        prevLoad = iloadA[0];
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 32'h30, 32'h0, 0, 1'b1);
        checkOutput("abort_count",      32'(resAborts), 32'd1);
        checkOutput("abort_cycle",      32'(resHitCyc), 32'd10);
        checkOutput("abort_ren_cycles", 32'(resRen),    32'd9);
        checkOutput("abort_ihits",      32'(resIHits),  32'd0);
        checkOutput("abort_iload",      iloadA[0],      prevLoad);

        // Both ports held for four transactions, starting from reset
        doReset();
        rst         = 1'b0;
        ramWait     = 1;
        useAddrData = 1'b1;
        seq0        = '0;
        seq1        = '0;
        n0          = 0;
        n1          = 0;
        fpIHits     = 0;
        iaddr       = 32'h100;
        daddr       = 32'h200;
        iren        = 1'b1;
        dren        = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (ihitA[1]) fpIHits++;
            if (ihitA[0] || dhitA[0]) begin
                seq0 = {seq0[2:0], dhitA[0]};
                n0++;
            end
            if (dhitA[1]) begin
                seq1 = {seq1[2:0], 1'b1};
                n1++;
            end
            if (n0 == 4) begin
                iren = 1'b0;
                dren = 1'b0;
            end
        end
        checkOutput("rr_count",    32'(n0),       32'd4);
        checkOutput("rr_order",    32'(seq0),     32'b1010);
        checkOutput("rr_iload",    iloadA[0],     32'h100 ^ ADDR_KEY);
        checkOutput("rr_dload",    dloadA[0],     32'h200 ^ ADDR_KEY);
        checkOutput("fp_count",    32'(n1),       32'd4);
        checkOutput("fp_order",    32'(seq1),     32'b1111);
        checkOutput("fp_ihits",    32'(fpIHits),  32'd0);
        checkOutput("fp_iload",    iloadA[1],     32'h0);
        useAddrData = 1'b0;

        // Reset landing in WAIT clears everything, then a normal read follows
        @(negedge clk);
        ramWait = 5;
        iaddr   = 32'h40;
        iren    = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk);
        rst  = 1'b1;
        iren = 1'b0;
        @(negedge clk);
        checkOutput("midrst_enables", 32'({ramRen[0], ramWen[0], ramRen[1], ramWen[1]}), 32'h0);
        checkOutput("midrst_pulses",  32'({ihitA[0], dhitA[0], abortA[0]}), 32'h0);
        checkOutput("midrst_ram_bus", ramAddr[0] | ramStore[0], 32'h0);
        checkOutput("midrst_loads",   iloadA[0] | dloadA[0], 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_hit",  32'(ihitA[0]), 32'h0);
        ramData = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h44, 32'h0, 0, 1'b0);
        checkOutput("post_rst_latency", 32'(resHitCyc), 32'd3);
        checkOutput("post_rst_ihits",   32'(resIHits),  32'd1);
        checkOutput("post_rst_iload",   iloadA[0],      32'hCAFE_F00D);

        @(negedge clk);
        checkOutput("exclusive_outputs", 32'(violations), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, 1 = round-robin when both ports request, 0 = fixed data-port priority.
REQ-002 SHALL have parameter RAM_WAIT_MAX, default 255, cycles waiting on ready before an abort.
REQ-003 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have iren  input  1  instruction read request, held until ihit.
REQ-006 SHALL have iaddr  input  32 (word_t)  instruction byte address.
REQ-007 SHALL have iload  output  32  instruction read data, valid with ihit.
REQ-008 SHALL have ihit  output  1  one-cycle instruction completion pulse.
REQ-009 SHALL have dren, dwen  input  1 each  data read and write requests, held until dhit.
REQ-010 SHALL have daddr, dstore  input  32 each  data address and write data.
REQ-011 SHALL have dload  output  32  data read data, valid with dhit.
REQ-012 SHALL have dhit  output  1  one-cycle data completion pulse.
REQ-013 SHALL have ram_addr, ram_store  output  32 each  to RAM addr and store.
REQ-014 SHALL have ram_ren, ram_wen  output  1 each  to RAM ren and wen.
REQ-015 SHALL have ram_load  input  32  and ram_ready  input  1  from RAM load and ready.
REQ-016 SHALL have abort  output  1  one-cycle pulse when a RAM access times out.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: with any request pending, SHALL latch the granted port's address, write data and op, then go to ISSUE on the next edge.
REQ-019 ISSUE: SHALL drive exactly one of ram_ren or ram_wen for one cycle and ignore ram_ready, then go to WAIT.
REQ-020 WAIT: SHALL hold ram_addr, ram_store and the enable stable until ram_ready=1 is sampled, then go to RESP.
REQ-021 RESP: SHALL deassert ram_ren and ram_wen, pulse the granted hit, register ram_load into iload or dload for reads, then go to IDLE.
REQ-022 SHALL keep dload unchanged on writes and keep iload and dload unchanged except in RESP.
REQ-023 Latency SHALL be request seen in IDLE at cycle N, then ram enable in N+1, then hit in the cycle after ram_ready is sampled; minimum N+3 for a RAM with zero wait.
REQ-024 Arbitration: with one requester, SHALL grant that requester.
REQ-025 Arbitration: with both requesting and RR_EN=1, SHALL grant the port not granted last; with RR_EN=0, SHALL always grant data.
REQ-026 The last-grant flag SHALL reset to instruction, so data wins the first conflict.
REQ-027 With dren and dwen both high, SHALL perform a write.
REQ-028 Requests SHALL be sampled only in IDLE; changes to port inputs during ISSUE, WAIT or RESP SHALL have no effect.
REQ-029 A requester dropping its request on the edge after hit SHALL NOT cause a duplicate access.
REQ-030 A cycle counter in WAIT SHALL cause the following on reaching RAM_WAIT_MAX: deassert the RAM enables, pulse abort, give no hit, return to IDLE.
REQ-031 At most one of ihit, dhit or abort SHALL be high in any cycle.
REQ-032 At most one of ram_ren or ram_wen SHALL be high in any cycle.

Reset
REQ-033 rst=1 SHALL force IDLE and drive 0 on all outputs and registers (ram_*, iload, dload, ihit, dhit, abort, wait counter, last-grant flag) at the next edge.
REQ-034 Reset mid-access SHALL drop the RAM enables at that edge and emit no hit.

Structure
REQ-035 word_t SHALL come from common_types_pkg.
REQ-036 arb_state_t (IDLE, ISSUE, WAIT, RESP) and grant_t (GRANT_I, GRANT_D) SHALL be added to common_types_pkg.
REQ-037 The design SHALL be a single module with no sub-module; the RAM and its ready behaviour stay external.

Verification
REQ-038 Bench SHALL cover: iren=1, iaddr=0x10, RAM returns 0xDEADBEEF after 3 wait cycles -> ihit one cycle with iload=0xDEADBEEF; ram_ren high for exactly 4 cycles.
REQ-039 Bench SHALL cover: dwen=1, daddr=0x20, dstore=0x12345678 -> ram_wen=1 with ram_addr=0x20 and ram_store=0x12345678 held until ready; dhit pulses; dload unchanged.
REQ-040 Bench SHALL cover: iren and dren both held high for 4 transactions, RR_EN=1 -> grant order D,I,D,I; with RR_EN=0 -> all four accesses to D while iren waits.
REQ-041 Bench SHALL cover: dren and dwen both high -> write performed and ram_ren never asserted.
REQ-042 Bench SHALL cover: ram_ready held 0 with RAM_WAIT_MAX=8 -> abort pulses 8 cycles after WAIT entry, no hit, then IDLE.
REQ-043 Bench SHALL cover: rst=1 asserted during WAIT -> next cycle all outputs 0; a following iren completes normally.
